// File: rtl/ahblite_slave_mux_if.sv
// AHB-Lite response-side bundle between master/decoder/slaves and the slave mux.
// Latency: none (wires only).
// Backpressure: HREADY carried back to the master and every slave.
interface ahblite_slave_mux_if;
  logic [1:0]  HTRANS;
  logic        HSEL_P0, HSEL_P1, HSEL_P2, HSEL_P3, HSEL_P4;
  logic [31:0] HRDATA_P0, HRDATA_P1, HRDATA_P2, HRDATA_P3, HRDATA_P4;
  logic        HREADYOUT_P0, HREADYOUT_P1, HREADYOUT_P2, HREADYOUT_P3, HREADYOUT_P4;
  logic        HRESP_P0, HRESP_P1, HRESP_P2, HRESP_P3, HRESP_P4;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        TIMEOUT_FLAG;

  // Mux side: consumes transfer/select/slave responses, produces the merged response.
  modport slave (
    input  HTRANS,
    input  HSEL_P0, HSEL_P1, HSEL_P2, HSEL_P3, HSEL_P4,
    input  HRDATA_P0, HRDATA_P1, HRDATA_P2, HRDATA_P3, HRDATA_P4,
    input  HREADYOUT_P0, HREADYOUT_P1, HREADYOUT_P2, HREADYOUT_P3, HREADYOUT_P4,
    input  HRESP_P0, HRESP_P1, HRESP_P2, HRESP_P3, HRESP_P4,
    output HRDATA, HREADY, HRESP, TIMEOUT_FLAG
  );

  // Fabric side: master, decoder and slaves driving into the mux.
  modport master (
    output HTRANS,
    output HSEL_P0, HSEL_P1, HSEL_P2, HSEL_P3, HSEL_P4,
    output HRDATA_P0, HRDATA_P1, HRDATA_P2, HRDATA_P3, HRDATA_P4,
    output HREADYOUT_P0, HREADYOUT_P1, HREADYOUT_P2, HREADYOUT_P3, HREADYOUT_P4,
    output HRESP_P0, HRESP_P1, HRESP_P2, HRESP_P3, HRESP_P4,
    input  HRDATA, HREADY, HRESP, TIMEOUT_FLAG
  );
endinterface

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite slave response mux with built-in default (ERROR) slave; optional timeout via AHB_MUX_TIMEOUT_EN.
// Latency: mapped transfers add 0 cycles; unmapped transfers take exactly 2 data-phase cycles.
// Backpressure: selected slave's HREADYOUT drives global HREADY; address phase sampled only when HREADY=1.
module ahblite_slave_mux #(
  parameter bit          PORT0_EN       = 1'b1,
  parameter bit          PORT1_EN       = 1'b1,
  parameter bit          PORT2_EN       = 1'b1,
  parameter bit          PORT3_EN       = 1'b1,
  parameter bit          PORT4_EN       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                HCLK,
  input logic                HRESET,
  ahblite_slave_mux_if.slave bus
);

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_P0   = 3'd1,
    SEL_P1   = 3'd2,
    SEL_P2   = 3'd3,
    SEL_P3   = 3'd4,
    SEL_P4   = 3'd5,
    SEL_DEF  = 3'd6
  } sel_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_e;

  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  // The counter needs at least one stalled cycle before the ERROR pair.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ahblite_slave_mux: TIMEOUT_CYCLES must be >= 2");
  end

  sel_e        sel_q, sel_d;
  ds_e         ds_state, ds_next;
  logic [4:0]  hsel_m;
  logic        htrans_active;
  logic [31:0] hrdata;
  logic        hready, hresp;
  logic        port_rdy, port_resp, on_port;
  logic        timeout_hit;

  // Disabled ports look unmapped, so their selects fall through to the default slave.
  assign hsel_m = {bus.HSEL_P4 & PORT4_EN, bus.HSEL_P3 & PORT3_EN, bus.HSEL_P2 & PORT2_EN,
                   bus.HSEL_P1 & PORT1_EN, bus.HSEL_P0 & PORT0_EN};
  assign htrans_active = (bus.HTRANS == TR_NONSEQ) || (bus.HTRANS == TR_SEQ);

  // Address-phase decode: lowest enabled select wins, otherwise DEF for real transfers.
  always_comb begin
    sel_d = SEL_NONE;
    if      (hsel_m[0])     sel_d = SEL_P0;
    else if (hsel_m[1])     sel_d = SEL_P1;
    else if (hsel_m[2])     sel_d = SEL_P2;
    else if (hsel_m[3])     sel_d = SEL_P3;
    else if (hsel_m[4])     sel_d = SEL_P4;
    else if (htrans_active) sel_d = SEL_DEF;
  end

  // Data-phase mux from the registered select; NONE and DEF return zero data.
  always_comb begin
    hrdata    = '0;
    port_rdy  = 1'b1;
    port_resp = 1'b0;
    on_port   = 1'b0;
    case (sel_q)
      SEL_P0: begin hrdata = bus.HRDATA_P0; port_rdy = bus.HREADYOUT_P0; port_resp = bus.HRESP_P0; on_port = 1'b1; end
      SEL_P1: begin hrdata = bus.HRDATA_P1; port_rdy = bus.HREADYOUT_P1; port_resp = bus.HRESP_P1; on_port = 1'b1; end
      SEL_P2: begin hrdata = bus.HRDATA_P2; port_rdy = bus.HREADYOUT_P2; port_resp = bus.HRESP_P2; on_port = 1'b1; end
      SEL_P3: begin hrdata = bus.HRDATA_P3; port_rdy = bus.HREADYOUT_P3; port_resp = bus.HRESP_P3; on_port = 1'b1; end
      SEL_P4: begin hrdata = bus.HRDATA_P4; port_rdy = bus.HREADYOUT_P4; port_resp = bus.HRESP_P4; on_port = 1'b1; end
      default: ;
    endcase
  end

  // Default-slave FSM: ERR states override ready/resp; ERR2 accepts the next address.
  always_comb begin
    hready  = port_rdy;
    hresp   = port_resp;
    ds_next = ds_state;
    case (ds_state)
      DS_IDLE: begin
        if ((hready && (sel_d == SEL_DEF)) || timeout_hit) ds_next = DS_ERR1;
      end
      DS_ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        ds_next = DS_ERR2;
      end
      DS_ERR2: begin
        hready  = 1'b1;
        hresp   = 1'b1;
        ds_next = (sel_d == SEL_DEF) ? DS_ERR1 : DS_IDLE;
      end
      default: ds_next = DS_IDLE;
    endcase
  end

  // Select register and FSM state; the select only advances on a ready cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q    <= SEL_NONE;
      ds_state <= DS_IDLE;
    end else begin
      ds_state <= ds_next;
      if (hready) sel_q <= sel_d;
    end
  end

`ifdef AHB_MUX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;
  logic          timeout_flag_q;
  logic          stall;

  // Only a real slave inserting wait states counts; the ERR override never does.
  assign stall       = on_port && !port_rdy && (ds_state == DS_IDLE);
  assign timeout_hit = stall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Wait-state counter and sticky flag; the edge that completes the limit starts ERR1.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tcnt           <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      tcnt <= stall ? tcnt + 1'b1 : '0;
      if (timeout_hit) timeout_flag_q <= 1'b1;
    end
  end

  assign bus.TIMEOUT_FLAG = timeout_flag_q;
`else
  assign timeout_hit      = 1'b0;
  assign bus.TIMEOUT_FLAG = 1'b0;
`endif

  assign bus.HRDATA = hrdata;
  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench for ahblite_slave_mux (PORT1 disabled, TIMEOUT_CYCLES=16).
// Inputs are driven and outputs sampled around the falling edge.
// Both builds of AHB_MUX_TIMEOUT_EN are covered by the stuck-slave section.
module tb_ahblite_slave_mux;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ahblite_slave_mux_if bus ();

  ahblite_slave_mux #(
    .PORT0_EN(1'b1), .PORT1_EN(1'b0), .PORT2_EN(1'b1), .PORT3_EN(1'b1), .PORT4_EN(1'b1),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .HCLK  (clk),
    .HRESET(rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic rdy, input logic resp, input logic [31:0] data);
    chk({tag, ".hready"}, {31'd0, bus.HREADY}, {31'd0, rdy});
    chk({tag, ".hresp"},  {31'd0, bus.HRESP},  {31'd0, resp});
    chk({tag, ".hrdata"}, bus.HRDATA, data);
  endtask

  task automatic set_sel(input logic [4:0] s, input logic [1:0] t);
    bus.HSEL_P0 = s[0];
    bus.HSEL_P1 = s[1];
    bus.HSEL_P2 = s[2];
    bus.HSEL_P3 = s[3];
    bus.HSEL_P4 = s[4];
    bus.HTRANS  = t;
  endtask

  initial begin
    int low_cnt;
    rst = 1'b1;
    set_sel(5'b00000, IDLE);
    bus.HRDATA_P0 = 32'hDEAD_0000; bus.HREADYOUT_P0 = 1'b1; bus.HRESP_P0 = 1'b0;
    bus.HRDATA_P1 = 32'hDEAD_0001; bus.HREADYOUT_P1 = 1'b1; bus.HRESP_P1 = 1'b0;
    bus.HRDATA_P2 = 32'hDEAD_0002; bus.HREADYOUT_P2 = 1'b1; bus.HRESP_P2 = 1'b0;
    bus.HRDATA_P3 = 32'hDEAD_0003; bus.HREADYOUT_P3 = 1'b1; bus.HRESP_P3 = 1'b0;
    bus.HRDATA_P4 = 32'hDEAD_0004; bus.HREADYOUT_P4 = 1'b1; bus.HRESP_P4 = 1'b0;

    // Reset held for two rising edges.
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk_bus("reset", 1'b1, 1'b0, 32'h0);
    chk("reset.flag", {31'd0, bus.TIMEOUT_FLAG}, 32'd0);

    // Zero-wait read from P2; P3 raising an error while unselected must be ignored.
    set_sel(5'b00100, NONSEQ);
    @(negedge clk);
    set_sel(5'b00000, IDLE);
    bus.HRDATA_P2 = 32'hA5A5_0001; bus.HRESP_P3 = 1'b1;
    #1 chk_bus("p2_read", 1'b1, 1'b0, 32'hA5A5_0001);

    // P3 read with three wait states; HSEL_P4 toggled during the wait must not be sampled.
    bus.HRESP_P3 = 1'b0; bus.HREADYOUT_P3 = 1'b0; bus.HRDATA_P3 = 32'h3333_0003;
    bus.HRDATA_P4 = 32'h4444_0004;
    set_sel(5'b01000, NONSEQ);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_sel(5'b10000, NONSEQ);
      #1 chk("p3_wait.hready", {31'd0, bus.HREADY}, 32'd0);
    end
    @(negedge clk);
    set_sel(5'b00000, IDLE); bus.HREADYOUT_P3 = 1'b1;
    #1 chk_bus("p3_data", 1'b1, 1'b0, 32'h3333_0003);
    @(negedge clk); #1 chk_bus("p3_after", 1'b1, 1'b0, 32'h0);

    // Unmapped NONSEQ: two-cycle ERROR then zero-wait OKAY on IDLE.
    set_sel(5'b00000, NONSEQ);
    @(negedge clk); set_sel(5'b00000, IDLE);
    #1 chk_bus("def_err1", 1'b0, 1'b1, 32'h0);
    @(negedge clk); #1 chk_bus("def_err2", 1'b1, 1'b1, 32'h0);
    @(negedge clk); #1 chk_bus("def_done", 1'b1, 1'b0, 32'h0);

    // Disabled P1 selected twice back-to-back: two ERROR pairs with no OKAY gap.
    set_sel(5'b00010, NONSEQ); bus.HRDATA_P1 = 32'h1111_0001;
    @(negedge clk); #1 chk_bus("p1off_err1a", 1'b0, 1'b1, 32'h0);
    @(negedge clk); #1 chk_bus("p1off_err2a", 1'b1, 1'b1, 32'h0);
    @(negedge clk); set_sel(5'b00000, IDLE);
    #1 chk_bus("p1off_err1b", 1'b0, 1'b1, 32'h0);
    @(negedge clk); #1 chk_bus("p1off_err2b", 1'b1, 1'b1, 32'h0);
    @(negedge clk); set_sel(5'b00000, BUSY);
    #1 chk_bus("idle_okay", 1'b1, 1'b0, 32'h0);
    @(negedge clk); #1 chk_bus("busy_okay", 1'b1, 1'b0, 32'h0);

    // Two selects at once: lowest index (P0) wins, including its error response.
    set_sel(5'b00101, SEQ);
    bus.HRDATA_P0 = 32'h0000_00A0; bus.HRESP_P0 = 1'b1;
    @(negedge clk); set_sel(5'b00000, NONSEQ);
    #1 chk_bus("prio_p0", 1'b1, 1'b1, 32'h0000_00A0);
    bus.HRESP_P0 = 1'b0;

    // Reset while the default slave is in ERR1.
    @(negedge clk); #1 chk("rst_err1.pre", {31'd0, bus.HREADY}, 32'd0);
    rst = 1'b1; set_sel(5'b00000, IDLE);
    @(negedge clk); rst = 1'b0;
    #1 chk_bus("rst_err1.post", 1'b1, 1'b0, 32'h0);

    // Reset while P3 is inserting wait states.
    set_sel(5'b01000, NONSEQ); bus.HREADYOUT_P3 = 1'b0;
    @(negedge clk); set_sel(5'b00000, IDLE);
    #1 chk("rst_wait.pre", {31'd0, bus.HREADY}, 32'd0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 chk_bus("rst_wait.post", 1'b1, 1'b0, 32'h0);
    bus.HREADYOUT_P3 = 1'b1;

    // P0 stuck not-ready: sixteen slave wait cycles first in either build.
    set_sel(5'b00001, NONSEQ); bus.HREADYOUT_P0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); set_sel(5'b00000, IDLE);
      #1 chk("stuck_wait", {30'd0, bus.HREADY, bus.HRESP}, 32'd0);
    end
`ifdef AHB_MUX_TIMEOUT_EN
    @(negedge clk); #1
    chk("to_err1.hready", {31'd0, bus.HREADY}, 32'd0);
    chk("to_err1.hresp",  {31'd0, bus.HRESP},  32'd1);
    @(negedge clk); #1
    chk("to_err2.hready", {31'd0, bus.HREADY}, 32'd1);
    chk("to_err2.hresp",  {31'd0, bus.HRESP},  32'd1);
    @(negedge clk); #1
    chk_bus("to_done", 1'b1, 1'b0, 32'h0);
    chk("to_flag", {31'd0, bus.TIMEOUT_FLAG}, 32'd1);
`else
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (bus.HREADY === 1'b0) low_cnt++;
    end
    chk("stuck_low_cycles", low_cnt, 32'd100);
    chk("stuck_flag", {31'd0, bus.TIMEOUT_FLAG}, 32'd0);
`endif

    // Reset clears everything, including the sticky flag.
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; bus.HREADYOUT_P0 = 1'b1;
    #1 chk_bus("final_reset", 1'b1, 1'b0, 32'h0);
    chk("final_flag", {31'd0, bus.TIMEOUT_FLAG}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
